// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the VGA timing generator: 640x480@60 defaults,
// derived totals, sync polarity codes and a helper for axis totals.
package vga_timing_pkg;

  localparam int DEF_CW = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int POL_ACTIVE_LOW  = 0;
  localparam int POL_ACTIVE_HIGH = 1;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus active/sync window decode.
// The window flags describe the value the counter will hold after this cycle.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CW     = DEF_CW,
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          wrap_o,
  output logic          in_active_o,
  output logic          in_sync_o
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  if (TOTAL > (1 << CW)) begin : g_bad_total
    $error("vga_axis_counter: ACTIVE+FP+SYNC+BP does not fit in CW bits");
  end

  localparam logic [CW-1:0] LAST      = CW'(TOTAL - 1);
  localparam logic [CW:0]   ACT_END   = (CW+1)'(ACTIVE);
  localparam logic [CW:0]   SYNC_BEG  = (CW+1)'(ACTIVE + FP);
  localparam logic [CW:0]   SYNC_END  = (CW+1)'(ACTIVE + FP + SYNC);

  logic [CW-1:0] count_q, count_d;
  logic [CW:0]   count_wide;

  assign wrap_o = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = wrap_o ? '0 : count_q + CW'(1);
    end
  end

  // One spare bit so window ends equal to 2**CW still compare correctly.
  assign count_wide  = {1'b0, count_d};
  assign in_active_o = (count_wide < ACT_END);
  assign in_sync_o   = (count_wide >= SYNC_BEG) && (count_wide < SYNC_END);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: x/y position, HS/VS, blank and frame/vblank strobes,
// all describing the same pixel in the same cycle, advancing on CE.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CW       = DEF_CW,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = POL_ACTIVE_LOW,
  parameter int VS_POL   = POL_ACTIVE_LOW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CE,
  output logic          HS,
  output logic          VS,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          blank,
  output logic          frame_start,
  output logic          vblank_start
);

  localparam logic          HS_ON      = (HS_POL != 0);
  localparam logic          VS_ON      = (VS_POL != 0);
  localparam logic [CW-1:0] V_PRE_BLANK = CW'(V_ACTIVE - 1);

  logic h_wrap, h_active, h_sync;
  logic v_wrap, v_active, v_sync;
  logic v_inc;

  assign v_inc = CE & h_wrap;

  vga_axis_counter #(
    .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk_i       (CLK),
    .rst_i       (RST),
    .inc_i       (CE),
    .count_o     (x),
    .wrap_o      (h_wrap),
    .in_active_o (h_active),
    .in_sync_o   (h_sync)
  );

  vga_axis_counter #(
    .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk_i       (CLK),
    .rst_i       (RST),
    .inc_i       (v_inc),
    .count_o     (y),
    .wrap_o      (v_wrap),
    .in_active_o (v_active),
    .in_sync_o   (v_sync)
  );

  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic blank_q, blank_d;
  logic fs_q, fs_d;
  logic vb_q, vb_d;

  // Decodes are taken from the counters' next values so the registered
  // flags land in the same cycle as the new x/y.
  always_comb begin
    hs_d    = hs_q;
    vs_d    = vs_q;
    blank_d = blank_q;
    fs_d    = fs_q;
    vb_d    = vb_q;
    if (CE) begin
      hs_d    = h_sync ? HS_ON : ~HS_ON;
      vs_d    = v_sync ? VS_ON : ~VS_ON;
      blank_d = ~(h_active & v_active);
      fs_d    = h_wrap & v_wrap;
      vb_d    = h_wrap & (y == V_PRE_BLANK);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hs_q    <= ~HS_ON;
      vs_q    <= ~VS_ON;
      blank_q <= 1'b0;
      fs_q    <= 1'b1;
      vb_q    <= 1'b0;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
      vb_q    <= vb_d;
    end
  end

  assign HS    = hs_q;
  assign VS    = vs_q;
  assign blank = blank_q;

  // fs_q marks "tuple is the origin"; gating with CE makes the strobe last one
  // pixel regardless of CE duty, and RST masks it while held in reset.
  assign frame_start  = CE & fs_q & ~RST;
  assign vblank_start = CE & vb_q & ~RST;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-CE bench for vga_timing_gen on a small raster, with a pixel-index
// reference model and a polarity-inverted second instance.
module tb_vga_timing_gen;

  localparam int CW    = 6;
  localparam int HA    = 16;
  localparam int HF    = 4;
  localparam int HSW   = 6;
  localparam int HB    = 4;
  localparam int VA    = 10;
  localparam int VF    = 2;
  localparam int VSW   = 2;
  localparam int VB    = 3;
  localparam int HT    = HA + HF + HSW + HB;
  localparam int VT    = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;

  always #5 clk = ~clk;

  logic          hs_n, vs_n, blank_n, fs_n, vb_n;
  logic [CW-1:0] x_n, y_n;
  logic          hs_p, vs_p, blank_p, fs_p, vb_p;
  logic [CW-1:0] x_p, y_p;

  vga_timing_gen #(
    .CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .HS_POL(0), .VS_POL(0)
  ) dut (
    .CLK(clk), .RST(rst), .CE(ce), .HS(hs_n), .VS(vs_n), .x(x_n), .y(y_n),
    .blank(blank_n), .frame_start(fs_n), .vblank_start(vb_n)
  );

  vga_timing_gen #(
    .CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .HS_POL(1), .VS_POL(1)
  ) dut_p (
    .CLK(clk), .RST(rst), .CE(ce), .HS(hs_p), .VS(vs_p), .x(x_p), .y(y_p),
    .blank(blank_p), .frame_start(fs_p), .vblank_start(vb_p)
  );

  int checks   = 0;
  int failures = 0;
  int n        = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t pix=%0d)", tag, got, exp, $time, n);
    end
  endtask

  task automatic check_all();
    int ex, ey, hs_on, vs_on, ebl, efs, evb;
    ex    = n % HT;
    ey    = n / HT;
    hs_on = (ex >= HA + HF && ex < HA + HF + HSW) ? 1 : 0;
    vs_on = (ey >= VA + VF && ey < VA + VF + VSW) ? 1 : 0;
    ebl   = (ex >= HA || ey >= VA) ? 1 : 0;
    efs   = (ce && !rst && ex == 0 && ey == 0) ? 1 : 0;
    evb   = (ce && !rst && ex == 0 && ey == VA) ? 1 : 0;
    check_val("x",          int'(x_n),     ex);
    check_val("y",          int'(y_n),     ey);
    check_val("hs_low",     int'(hs_n),    1 - hs_on);
    check_val("vs_low",     int'(vs_n),    1 - vs_on);
    check_val("blank",      int'(blank_n), ebl);
    check_val("frame_st",   int'(fs_n),    efs);
    check_val("vblank_st",  int'(vb_n),    evb);
    check_val("p_x",        int'(x_p),     ex);
    check_val("p_y",        int'(y_p),     ey);
    check_val("p_hs_high",  int'(hs_p),    hs_on);
    check_val("p_vs_high",  int'(vs_p),    vs_on);
    check_val("p_blank",    int'(blank_p), ebl);
    check_val("p_frame_st", int'(fs_p),    efs);
    check_val("p_vblank_st", int'(vb_p),   evb);
  endtask

  // Inputs change on the falling edge; a reset raised here is seen with no
  // rising edge in between, so the check below exercises the async path.
  task automatic step(input logic ce_v, input logic rst_v);
    @(negedge clk);
    ce  = ce_v;
    rst = rst_v;
    if (rst_v) n = 0;
    #1;
    check_all();
    if (ce && !rst) n = (n + 1) % FRAME;
  endtask

  initial begin
    int last_fs;
    int fs_seen;

    // Reset held with CE high.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);

    // Release: first CE cycle shows the origin with frame_start, then x=1.
    step(1'b1, 1'b0);
    check_val("rel_fs", int'(fs_n), 1);
    step(1'b1, 1'b0);
    check_val("rel_x1", int'(x_n), 1);

    // Free-running CE: frame_start period equals the frame size.
    last_fs = -1;
    fs_seen = 0;
    for (int i = 0; i < 2 * FRAME + 20; i++) begin
      step(1'b1, 1'b0);
      if (fs_n) begin
        if (last_fs >= 0) check_val("fs_period", i - last_fs, FRAME);
        last_fs = i;
        fs_seen++;
      end
    end
    check_val("fs_count_ce1", fs_seen, 2);

    // CE at half rate: strobes stay one cycle wide, period doubles.
    last_fs = -1;
    fs_seen = 0;
    for (int i = 0; i < 4 * FRAME + 4; i++) begin
      step(logic'(i % 2), 1'b0);
      if (fs_n) begin
        if (last_fs >= 0) check_val("fs_period_half", i - last_fs, 2 * FRAME);
        last_fs = i;
        fs_seen++;
      end
    end
    check_val("fs_count_half", fs_seen, 2);

    // Random CE, then an asynchronous reset mid-frame.
    for (int i = 0; i < FRAME / 2 + int'($urandom_range(0, 40)); i++)
      step(logic'($urandom_range(0, 1)), 1'b0);
    step(logic'($urandom_range(0, 1)), 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check_val("rerel_fs", int'(fs_n), 1);

    // Random-duty CE over a couple of frames.
    for (int i = 0; i < 3 * FRAME; i++)
      step(($urandom_range(0, 3) != 0), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
